// File: rtl/fifo_sync_rf_if.sv
// Push/pop handshake, read data and status bundle for fifo_sync_rf.
interface fifo_sync_rf_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              push;
    logic [DATA_W-1:0] wd;
    logic              pop;
    logic [DATA_W-1:0] rd;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;

    modport master (
        output push, wd, pop,
        input  rd, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  push, wd, pop,
        output rd, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_rf.sv
// Single-clock register-array FIFO with occupancy and sticky error flags.
// Latency: accepted pop presents data on rd with rd_valid one cycle later; no write-to-read bypass.
// Backpressure: push refused while full unless a pop is accepted the same cycle; pop refused while empty.
module fifo_sync_rf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int AF_LVL = 28,
    parameter int AE_LVL = 4
) (
    input logic           clk,
    input logic           rst_n,
    fifo_sync_rf_if.slave f
);
    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W + 1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W + 1)'(AE_LVL);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] rd_q;
    logic              rd_valid_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              full_w;
    logic              empty_w;
    logic              push_ok;
    logic              pop_ok;

    assign full_w  = (cnt == FULL_CNT);
    assign empty_w = (cnt == '0);
    assign pop_ok  = f.pop & ~empty_w;
    // A pop frees the slot this cycle, so a full FIFO still takes a simultaneous push.
    assign push_ok = f.push & (~full_w | pop_ok);

    // Store is intentionally not reset; pointers guarantee only post-reset data is read.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[wr_ptr] <= f.wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            cnt         <= '0;
            rd_q        <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_q   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            rd_valid_q <= pop_ok;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (f.push && full_w && !f.pop) begin
                overflow_q <= 1'b1;
            end
            if (f.pop && empty_w) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign f.rd           = rd_q;
    assign f.rd_valid     = rd_valid_q;
    assign f.count        = cnt;
    assign f.full         = full_w;
    assign f.empty        = empty_w;
    assign f.almost_full  = (cnt >= AF_CNT);
    assign f.almost_empty = (cnt <= AE_CNT);
    assign f.overflow     = overflow_q;
    assign f.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_rf.sv
// Directed and model-checked bench for fifo_sync_rf.
module tb_fifo_sync_rf;
    logic tb_clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    fifo_sync_rf_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    fifo_sync_rf #(.DATA_W(32), .ADDR_W(5), .AF_LVL(28), .AE_LVL(4)) dut (
        .clk   (tb_clk),
        .rst_n (rst_n),
        .f     (bus)
    );

    always #5 tb_clk = ~tb_clk;

    // Inputs change and outputs are sampled 1 time unit after each rising edge.
    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.wd = '0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (bus.count !== 6'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.almost_empty !== 1'b1) begin n_bad++; $display("FAIL reset_ae: got %b want 1", bus.almost_empty); end
        n_cmp++; if (bus.full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", bus.full); end
        n_cmp++; if (bus.almost_full !== 1'b0) begin n_bad++; $display("FAIL reset_af: got %b want 0", bus.almost_full); end
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.rd !== 32'h0) begin n_bad++; $display("FAIL reset_rd: got %h want 0", bus.rd); end
        n_cmp++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_bad++; $display("FAIL reset_err: got %b want 00", {bus.overflow, bus.underflow}); end
    endtask

    task automatic test_basic();
        logic [31:0] exp;
        for (int i = 1; i <= 4; i++) begin
            bus.push = 1'b1; bus.wd = 32'hA5A5_0000 + 32'(i);
            step();
        end
        bus.push = 1'b0;
        n_cmp++; if (bus.count !== 6'd4) begin n_bad++; $display("FAIL basic_count: got %0d want 4", bus.count); end
        n_cmp++; if (bus.almost_empty !== 1'b1) begin n_bad++; $display("FAIL basic_ae4: got %b want 1", bus.almost_empty); end
        for (int i = 1; i <= 4; i++) begin
            bus.pop = 1'b1;
            step();
            exp = 32'hA5A5_0000 + 32'(i);
            n_cmp++; if (bus.rd_valid !== 1'b1) begin n_bad++; $display("FAIL basic_rd_valid[%0d]: got %b want 1", i, bus.rd_valid); end
            n_cmp++; if (bus.rd !== exp) begin n_bad++; $display("FAIL basic_rd[%0d]: got %h want %h", i, bus.rd, exp); end
        end
        bus.pop = 1'b0;
        step();
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL basic_rd_valid_idle: got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.rd !== 32'hA5A5_0004) begin n_bad++; $display("FAIL basic_rd_hold: got %h want a5a50004", bus.rd); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL basic_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_fill_overflow();
        logic [31:0] words [32];
        for (int i = 0; i < 32; i++) begin
            words[i] = $urandom;
            bus.push = 1'b1; bus.wd = words[i];
            step();
            n_cmp++; if (bus.count !== 6'(i + 1)) begin n_bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, bus.count, i + 1); end
            n_cmp++; if (bus.almost_full !== (i + 1 >= 28)) begin n_bad++; $display("FAIL fill_af[%0d]: got %b want %b", i, bus.almost_full, (i + 1 >= 28)); end
            n_cmp++; if (bus.almost_empty !== (i + 1 <= 4)) begin n_bad++; $display("FAIL fill_ae[%0d]: got %b want %b", i, bus.almost_empty, (i + 1 <= 4)); end
        end
        n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", bus.full); end
        bus.wd = 32'h0BAD_0BAD;
        step();
        bus.push = 1'b0;
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
        n_cmp++; if (bus.count !== 6'd32) begin n_bad++; $display("FAIL ovf_count: got %0d want 32", bus.count); end
        for (int i = 0; i < 32; i++) begin
            bus.pop = 1'b1;
            step();
            n_cmp++; if (bus.rd !== words[i]) begin n_bad++; $display("FAIL ovf_rd[%0d]: got %h want %h", i, bus.rd, words[i]); end
        end
        bus.pop = 1'b0;
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL ovf_drain_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", bus.overflow); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 32; i++) begin
            bus.push = 1'b1; bus.wd = 32'h3000_0000 + 32'(i);
            step();
        end
        bus.pop = 1'b1; bus.wd = 32'hDEAD_BEEF;
        step();
        bus.push = 1'b0;
        n_cmp++; if (bus.count !== 6'd32) begin n_bad++; $display("FAIL fpp_count: got %0d want 32", bus.count); end
        n_cmp++; if (bus.full !== 1'b1) begin n_bad++; $display("FAIL fpp_full: got %b want 1", bus.full); end
        n_cmp++; if (bus.rd !== 32'h3000_0000) begin n_bad++; $display("FAIL fpp_first: got %h want 30000000", bus.rd); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL fpp_no_ovf: got %b want 0", bus.overflow); end
        for (int i = 1; i < 32; i++) begin
            step();
            n_cmp++; if (bus.rd !== 32'h3000_0000 + 32'(i)) begin n_bad++; $display("FAIL fpp_rd[%0d]: got %h want %h", i, bus.rd, 32'h3000_0000 + 32'(i)); end
        end
        step();
        bus.pop = 1'b0;
        n_cmp++; if (bus.rd !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL fpp_last: got %h want deadbeef", bus.rd); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL fpp_empty: got %b want 1", bus.empty); end
    endtask

    task automatic test_underflow();
        bus.push = 1'b1; bus.pop = 1'b1; bus.wd = 32'h1;
        step();
        bus.push = 1'b0;
        n_cmp++; if (bus.underflow !== 1'b1) begin n_bad++; $display("FAIL udf_flag: got %b want 1", bus.underflow); end
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL udf_rd_valid: got %b want 0", bus.rd_valid); end
        n_cmp++; if (bus.count !== 6'd1) begin n_bad++; $display("FAIL udf_count: got %0d want 1", bus.count); end
        step();
        bus.pop = 1'b0;
        n_cmp++; if (bus.rd !== 32'h1 || bus.rd_valid !== 1'b1) begin n_bad++; $display("FAIL udf_next_pop: got rd=%h vld=%b want rd=1 vld=1", bus.rd, bus.rd_valid); end
        n_cmp++; if (bus.count !== 6'd0) begin n_bad++; $display("FAIL udf_count_after: got %0d want 0", bus.count); end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [31:0] exp;
        logic        pop_m, push_m;
        int          pushes = 0;
        do_reset();
        for (int c = 0; c < 100; c++) begin
            bus.push = 1'b1;
            bus.pop  = ($urandom_range(0, 99) < 85);
            bus.wd   = $urandom;
            pop_m  = bus.pop && (q.size() > 0);
            push_m = bus.push && ((q.size() < 32) || pop_m);
            exp    = pop_m ? q[0] : 32'h0;
            if (pop_m) void'(q.pop_front());
            if (push_m) begin q.push_back(bus.wd); pushes++; end
            step();
            n_cmp++; if (bus.rd_valid !== pop_m) begin n_bad++; $display("FAIL rnd_rd_valid[%0d]: got %b want %b", c, bus.rd_valid, pop_m); end
            if (pop_m) begin
                n_cmp++; if (bus.rd !== exp) begin n_bad++; $display("FAIL rnd_rd[%0d]: got %h want %h", c, bus.rd, exp); end
            end
            n_cmp++; if (bus.count !== 6'(q.size())) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", c, bus.count, q.size()); end
        end
        bus.push = 1'b0; bus.pop = 1'b0;
        n_cmp++; if (pushes / 32 < 3) begin n_bad++; $display("FAIL rnd_wraps: got %0d want >=3", pushes / 32); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
        for (int i = 0; i < 11; i++) begin
            bus.push = 1'b1; bus.wd = 32'h6000_0000 + 32'(i);
            step();
        end
        bus.push = 1'b0; bus.pop = 1'b1;
        step();
        n_cmp++; if (bus.count !== 6'd10 || bus.underflow !== 1'b1 || bus.rd_valid !== 1'b1) begin n_bad++; $display("FAIL mid_pre: got cnt=%0d udf=%b vld=%b want cnt=10 udf=1 vld=1", bus.count, bus.underflow, bus.rd_valid); end
        rst_n = 1'b0; bus.push = 1'b1; bus.wd = 32'h9999_9999;
        step();
        rst_n = 1'b1; bus.push = 1'b0; bus.pop = 1'b0;
        n_cmp++; if (bus.count !== 6'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", bus.count); end
        n_cmp++; if (bus.empty !== 1'b1) begin n_bad++; $display("FAIL mid_empty: got %b want 1", bus.empty); end
        n_cmp++; if (bus.rd_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rd_valid: got %b want 0", bus.rd_valid); end
        n_cmp++; if ({bus.overflow, bus.underflow} !== 2'b00) begin n_bad++; $display("FAIL mid_err: got %b want 00", {bus.overflow, bus.underflow}); end
        bus.push = 1'b1; bus.wd = 32'h77;
        step();
        bus.push = 1'b0; bus.pop = 1'b1;
        step();
        bus.pop = 1'b0;
        n_cmp++; if (bus.rd !== 32'h77) begin n_bad++; $display("FAIL mid_fresh_rd: got %h want 77", bus.rd); end
    endtask

    initial begin
        rst_n = 1'b0; bus.push = 1'b0; bus.pop = 1'b0; bus.wd = '0;
        test_reset();
        test_basic();
        test_fill_overflow();
        test_full_push_pop();
        test_underflow();
        test_random();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
